// File: rtl/rv_pkg.sv
// Shared RISC-V constants for the write-back path: load funct3 encodings and
// the default datapath and register-address widths.
package rv_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [2:0] LOAD_LB  = 3'b000;
  localparam logic [2:0] LOAD_LH  = 3'b001;
  localparam logic [2:0] LOAD_LW  = 3'b010;
  localparam logic [2:0] LOAD_LD  = 3'b011;
  localparam logic [2:0] LOAD_LBU = 3'b100;
  localparam logic [2:0] LOAD_LHU = 3'b101;
  localparam logic [2:0] LOAD_LWU = 3'b110;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load formatter: picks the byte/half/word lane at the load
// offset and sign- or zero-extends it to XLEN. Misaligned offsets are not checked.
module wb_load_align
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [XLEN-1:0] fmt_o
);

  localparam int BW = $clog2(XLEN / 8);

  logic        wsel;
  logic [7:0]  b_lane;
  logic [15:0] h_lane;
  logic [31:0] w_lane;

  // Only a 64-bit datapath has two word lanes; a 32-bit one ignores addr_lo[2].
  assign wsel   = (XLEN == 64) ? addr_lo_i[2] : 1'b0;
  assign b_lane = 8'(raw_i >> {addr_lo_i[BW-1:0], 3'b000});
  assign h_lane = 16'(raw_i >> {addr_lo_i[BW-1:1], 4'b0000});
  assign w_lane = 32'(raw_i >> {wsel, 5'b00000});

  always_comb begin
    fmt_o = XLEN'($signed(w_lane));
    case (funct3_i)
      LOAD_LB:  fmt_o = XLEN'($signed(b_lane));
      LOAD_LH:  fmt_o = XLEN'($signed(h_lane));
      LOAD_LBU: fmt_o = XLEN'(b_lane);
      LOAD_LHU: fmt_o = XLEN'(h_lane);
      LOAD_LWU: if (XLEN == 64) fmt_o = XLEN'(w_lane);
      LOAD_LD:  if (XLEN == 64) fmt_o = raw_i;
      default:  ;
    endcase
  end

endmodule

// File: rtl/wb_stage_buf.sv
// Write-back stage: DEPTH-entry result buffer between MEM and the register
// file write port, with load formatting on entry and an instret counter.
module wb_stage_buf
  import rv_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [REG_AW-1:0] mem_wd,
  input  logic              mem_wreg,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_is_load,
  input  logic [2:0]        mem_funct3,
  input  logic [2:0]        mem_addr_lo,
  input  logic              wb_ready,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_wd,
  output logic              wb_wreg,
  output logic [XLEN-1:0]   wb_wdata,
  output logic [CNT_W-1:0]  instret
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [REG_AW-1:0] wd_q   [DEPTH];
  logic              wreg_q [DEPTH];
  logic [XLEN-1:0]   data_q [DEPTH];

  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic            push;
  logic            pop;
  logic [XLEN-1:0] fmt_data;
  logic [XLEN-1:0] in_data;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .funct3_i  (mem_funct3),
    .addr_lo_i (mem_addr_lo),
    .raw_i     (mem_wdata),
    .fmt_o     (fmt_data)
  );

  // Both sides are valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high. mem_ready comes from registered count only,
  // so a full buffer needs a pop before it will accept again.
  assign mem_ready = (count_q != FULL_CNT);
  assign wb_valid  = (count_q != '0);
  assign push      = mem_valid && mem_ready;
  assign pop       = wb_valid && wb_ready;
  assign in_data   = mem_is_load ? fmt_data : mem_wdata;

  assign wb_wd    = wb_valid ? wd_q[rd_ptr_q]   : '0;
  assign wb_wreg  = wb_valid ? wreg_q[rd_ptr_q] : 1'b0;
  assign wb_wdata = wb_valid ? data_q[rd_ptr_q] : '0;
  assign instret  = instret_q;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    instret_d = instret_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PW'(1);
      instret_d = instret_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      instret_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        wd_q[i]   <= '0;
        wreg_q[i] <= 1'b0;
        data_q[i] <= '0;
      end
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      instret_q <= instret_d;
      if (push) begin
        wd_q[wr_ptr_q]   <= mem_wd;
        // x0 is hardwired zero, so its write enable is dropped at entry.
        wreg_q[wr_ptr_q] <= mem_wreg && (mem_wd != '0);
        data_q[wr_ptr_q] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Bench for wb_stage_buf: directed and random traffic, expected entries queued
// at issue time and checked by a monitor whenever a result retires.
module tb_wb_stage_buf;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 64;
  localparam int W      = REG_AW + 1 + XLEN;

  logic              clk;
  logic              rst;
  logic              mem_valid;
  logic              mem_ready;
  logic [REG_AW-1:0] mem_wd;
  logic              mem_wreg;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_is_load;
  logic [2:0]        mem_funct3;
  logic [2:0]        mem_addr_lo;
  logic              wb_ready;
  logic              wb_valid;
  logic [REG_AW-1:0] wb_wd;
  logic              wb_wreg;
  logic [XLEN-1:0]   wb_wdata;
  logic [CNT_W-1:0]  instret;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           pend     = 0;
  longint       pops     = 0;

  wb_stage_buf #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_wd      (mem_wd),
    .mem_wreg    (mem_wreg),
    .mem_wdata   (mem_wdata),
    .mem_is_load (mem_is_load),
    .mem_funct3  (mem_funct3),
    .mem_addr_lo (mem_addr_lo),
    .wb_ready    (wb_ready),
    .wb_valid    (wb_valid),
    .wb_wd       (wb_wd),
    .wb_wreg     (wb_wreg),
    .wb_wdata    (wb_wdata),
    .instret     (instret)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference load formatting from the ISA rules with plain arithmetic.
  function automatic logic [31:0] ref_fmt(logic [31:0] raw, logic ld, logic [2:0] f3, logic [2:0] off);
    int unsigned b;
    int unsigned h;
    if (!ld) return raw;
    b = (raw >> (8 * off[1:0])) % 256;
    h = (raw >> (16 * off[1])) % 65536;
    case (f3)
      3'd0:    return (b < 128) ? b : b + 32'hFFFF_FF00;
      3'd1:    return (h < 32768) ? h : h + 32'hFFFF_0000;
      3'd4:    return b;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  function automatic logic [W-1:0] pack(logic [REG_AW-1:0] wd, logic wreg, logic [XLEN-1:0] d);
    return {wd, wreg && (wd != 0), d};
  endfunction

  // driver: one cycle of stimulus, inputs change 2 time units after the edge
  task automatic drive(input logic v, input logic [REG_AW-1:0] wd, input logic wreg,
                       input logic [XLEN-1:0] raw, input logic ld, input logic [2:0] f3,
                       input logic [2:0] off, input logic wbr, input logic [XLEN-1:0] exp_d,
                       output logic taken);
    @(posedge clk);
    #2;
    mem_valid   = v;
    mem_wd      = wd;
    mem_wreg    = wreg;
    mem_wdata   = raw;
    mem_is_load = ld;
    mem_funct3  = f3;
    mem_addr_lo = off;
    wb_ready    = wbr;
    taken       = v && mem_ready;
    pend        = taken ? 1 : 0;
    if (taken) exp_q.push_back(pack(wd, wreg, exp_d));
  endtask

  task automatic push_one(input logic [REG_AW-1:0] wd, input logic wreg, input logic [XLEN-1:0] raw,
                          input logic ld, input logic [2:0] f3, input logic [2:0] off, input logic wbr);
    logic t;
    drive(1'b1, wd, wreg, raw, ld, f3, off, wbr, ref_fmt(raw, ld, f3, off), t);
  endtask

  task automatic idle(input int n, input logic wbr);
    logic t;
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 3'd0, 3'd0, wbr, '0, t);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    int occ;
    if (rst) begin
      occ = exp_q.size() - pend;
      check("mem_ready", 64'(mem_ready), 64'(occ != DEPTH));
      check("wb_valid", 64'(wb_valid), 64'(occ != 0));
      check("instret", instret, 64'(pops));
      if (!wb_valid) begin
        check("idle_outputs_zero", 64'({wb_wd, wb_wreg, wb_wdata}), 64'd0);
      end else if (wb_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 64'({wb_wd, wb_wreg, wb_wdata}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("wb_entry", 64'({wb_wd, wb_wreg, wb_wdata}), 64'(exp_q.pop_front()));
          pops++;
        end
      end
    end
  end

  task automatic async_reset_check();
    rst       = 1'b0;
    mem_valid = 1'b0;
    exp_q.delete();
    pops = 0;
    pend = 0;
    #1;
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_wb_fields", 64'({wb_wd, wb_wreg, wb_wdata}), 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_mem_ready", 64'(mem_ready), 64'd1);
  endtask

  initial begin
    logic t;
    rst         = 1'b0;
    mem_valid   = 1'b1;
    mem_wd      = 5'd9;
    mem_wreg    = 1'b1;
    mem_wdata   = 32'hCAFE_F00D;
    mem_is_load = 1'b0;
    mem_funct3  = 3'd0;
    mem_addr_lo = 3'd0;
    wb_ready    = 1'b1;

    // reset held with mem_valid asserted
    repeat (3) @(posedge clk);
    #3;
    check("reset_wb_valid", 64'(wb_valid), 64'd0);
    check("reset_wb_fields", 64'({wb_wd, wb_wreg, wb_wdata}), 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_mem_ready", 64'(mem_ready), 64'd1);
    mem_valid = 1'b0;
    rst       = 1'b1;
    idle(3, 1'b1);

    // streaming
    for (int i = 1; i <= 4; i++) push_one(REG_AW'(i), 1'b1, 32'(8'h11 * i), 1'b0, 3'd0, 3'd0, 1'b1);
    idle(2, 1'b1);
    check("stream_instret", instret, 64'd4);

    // backpressure
    push_one(5'd5, 1'b1, 32'h0000_0505, 1'b0, 3'd0, 3'd0, 1'b0);
    push_one(5'd6, 1'b1, 32'h0000_0606, 1'b0, 3'd0, 3'd0, 1'b0);
    drive(1'b1, 5'd7, 1'b1, 32'h0000_0707, 1'b0, 3'd0, 3'd0, 1'b0, 32'h0000_0707, t);
    check("full_not_taken", 64'(t), 64'd0);
    idle(1, 1'b0);
    idle(3, 1'b1);
    check("bp_instret", instret, 64'd6);

    // loads with fixed expected values
    drive(1'b1, 5'd10, 1'b1, 32'h80FF_7F01, 1'b1, 3'b000, 3'd3, 1'b1, 32'hFFFF_FF80, t);
    drive(1'b1, 5'd11, 1'b1, 32'h80FF_7F01, 1'b1, 3'b100, 3'd3, 1'b1, 32'h0000_0080, t);
    drive(1'b1, 5'd12, 1'b1, 32'h80FF_7F01, 1'b1, 3'b001, 3'd2, 1'b1, 32'hFFFF_80FF, t);
    drive(1'b1, 5'd13, 1'b1, 32'h80FF_7F01, 1'b1, 3'b101, 3'd0, 1'b1, 32'h0000_7F01, t);
    drive(1'b1, 5'd14, 1'b1, 32'h80FF_7F01, 1'b1, 3'b110, 3'd1, 1'b1, 32'h80FF_7F01, t);
    drive(1'b1, 5'd15, 1'b1, 32'h80FF_7F01, 1'b1, 3'b011, 3'd0, 1'b1, 32'h80FF_7F01, t);

    // x0 write suppression
    push_one(5'd0, 1'b1, 32'h0000_DEAD, 1'b0, 3'd0, 3'd0, 1'b1);
    idle(2, 1'b1);
    check("x0_instret", instret, 64'd13);

    // push and pop in one cycle at count 1, then fill and pop-only from full
    push_one(5'd20, 1'b1, 32'hA0A0_0001, 1'b0, 3'd0, 3'd0, 1'b0);
    push_one(5'd21, 1'b1, 32'hA0A0_0002, 1'b0, 3'd0, 3'd0, 1'b1);
    push_one(5'd22, 1'b1, 32'hA0A0_0003, 1'b0, 3'd0, 3'd0, 1'b1);
    push_one(5'd23, 1'b1, 32'hA0A0_0004, 1'b0, 3'd0, 3'd0, 1'b0);
    idle(3, 1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 7)
        push_one(REG_AW'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 9) < 6));
      else
        idle(1, 1'($urandom_range(0, 9) < 6));
    end
    idle(DEPTH + 2, 1'b1);
    check("drained", 64'(exp_q.size()), 64'd0);

    // reset mid-stream with a full buffer
    push_one(5'd3, 1'b1, 32'h1234_5678, 1'b0, 3'd0, 3'd0, 1'b0);
    push_one(5'd4, 1'b1, 32'h8765_4321, 1'b0, 3'd0, 3'd0, 1'b0);
    @(posedge clk);
    #2;
    async_reset_check();
    #4;
    rst = 1'b1;
    idle(2, 1'b1);
    push_one(5'd8, 1'b1, 32'h0BAD_F00D, 1'b1, 3'b010, 3'd0, 1'b1);
    push_one(5'd9, 1'b0, 32'h0000_00F0, 1'b1, 3'b000, 3'd0, 1'b1);
    idle(3, 1'b1);
    check("post_reset_instret", instret, 64'd2);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
